// File: rtl/vault_if.sv
// Handshake bundle between the vault sequencer and the puzzle phases / test driver.
interface vault_if #(
    parameter int unsigned NUM_PHASES = 5
);
    logic                  start;
    logic                  abort;
    logic [NUM_PHASES-1:0] phase_done;
    logic [NUM_PHASES-1:0] phase_fail;
    logic [NUM_PHASES-1:0] phase_rst;
    logic [NUM_PHASES-1:0] phase_en;
    logic [2:0]            cur_phase;
    logic [3:0]            fail_cnt;
    logic                  busy;
    logic                  vault_open;
    logic                  alarm;

    modport master (
        output start, abort, phase_done, phase_fail,
        input  phase_rst, phase_en, cur_phase, fail_cnt, busy, vault_open, alarm
    );

    modport slave (
        input  start, abort, phase_done, phase_fail,
        output phase_rst, phase_en, cur_phase, fail_cnt, busy, vault_open, alarm
    );
endinterface

// File: rtl/vault_sequencer.sv
// Sequences the vault puzzle phases one at a time, with retry budget, lockout alarm and open flag.
// Phase controls and status flags are registered decodes of the current state.
module vault_sequencer #(
    parameter int unsigned NUM_PHASES     = 5,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned PHASE_TIMEOUT  = 64,
    parameter int unsigned RST_CYCLES     = 2,
    parameter int unsigned LOCKOUT_CYCLES = 100
) (
    input logic    clk,
    input logic    reset,
    vault_if.slave bus
);
    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StRstPhase = 3'd1;
    localparam logic [2:0] StRun      = 3'd2;
    localparam logic [2:0] StAdvance  = 3'd3;
    localparam logic [2:0] StFail     = 3'd4;
    localparam logic [2:0] StOpen     = 3'd5;
    localparam logic [2:0] StLockout  = 3'd6;

    localparam int unsigned RstW   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned TimerW = (PHASE_TIMEOUT > 1) ? $clog2(PHASE_TIMEOUT) : 1;
    localparam int unsigned LockW  = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam int unsigned CntW0  = (RstW > TimerW) ? RstW : TimerW;
    localparam int unsigned CntW   = (CntW0 > LockW) ? CntW0 : LockW;

    logic [2:0]            state_q, state_d;
    logic [2:0]            cur_q, cur_d;
    logic [3:0]            fail_q, fail_d, fail_inc;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  active_done, active_fail;
    logic [NUM_PHASES-1:0] rst_d, en_d;
    logic                  busy_d, open_d, alarm_d;

    assign active_done = bus.phase_done[cur_q];
    assign active_fail = bus.phase_fail[cur_q];
    assign fail_inc    = (fail_q == 4'hf) ? 4'hf : fail_q + 4'd1;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        fail_d  = fail_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StRstPhase;
                    cur_d   = 3'd0;
                    fail_d  = 4'd0;
                end
            end
            StRstPhase: begin
                if (cnt_q == CntW'(RST_CYCLES - 1)) state_d = StRun;
            end
            StRun: begin
                // A fail outranks a done seen in the same cycle.
                if (active_fail) state_d = StFail;
                else if (active_done) state_d = StAdvance;
                else if (cnt_q == CntW'(PHASE_TIMEOUT - 1)) state_d = StFail;
            end
            StAdvance: begin
                if (cur_q == 3'(NUM_PHASES - 1)) begin
                    state_d = StOpen;
                end else begin
                    cur_d   = cur_q + 3'd1;
                    state_d = StRstPhase;
                end
            end
            StFail: begin
                fail_d  = fail_inc;
                state_d = (32'(fail_inc) >= MAX_RETRIES) ? StLockout : StRstPhase;
            end
            StOpen: state_d = StOpen;
            StLockout: begin
                if (cnt_q == CntW'(LOCKOUT_CYCLES - 1)) begin
                    state_d = StIdle;
                    fail_d  = 4'd0;
                end
            end
            default: state_d = StIdle;
        endcase
        if (bus.abort) begin
            state_d = StIdle;
            cur_d   = 3'd0;
            fail_d  = 4'd0;
        end
        cnt_d = (state_d != state_q) ? '0 : cnt_q + CntW'(1);
    end

    always_comb begin
        rst_d   = '1;
        en_d    = '0;
        busy_d  = 1'b0;
        open_d  = 1'b0;
        alarm_d = 1'b0;
        if (!bus.abort) begin
            unique case (state_q)
                StRstPhase, StAdvance: busy_d = 1'b1;
                StRun: begin
                    busy_d       = 1'b1;
                    rst_d[cur_q] = 1'b0;
                    en_d[cur_q]  = 1'b1;
                end
                StOpen:    open_d  = 1'b1;
                StLockout: alarm_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            cur_q          <= 3'd0;
            fail_q         <= 4'd0;
            cnt_q          <= '0;
            bus.phase_rst  <= '1;
            bus.phase_en   <= '0;
            bus.busy       <= 1'b0;
            bus.vault_open <= 1'b0;
            bus.alarm      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cur_q          <= cur_d;
            fail_q         <= fail_d;
            cnt_q          <= cnt_d;
            bus.phase_rst  <= rst_d;
            bus.phase_en   <= en_d;
            bus.busy       <= busy_d;
            bus.vault_open <= open_d;
            bus.alarm      <= alarm_d;
        end
    end

    assign bus.cur_phase = cur_q;
    assign bus.fail_cnt  = fail_q;
endmodule

// File: tb/tb_vault_sequencer.sv
// Directed bench for vault_sequencer: happy path, retry, timeout, lockout, spurious inputs, abort/reset.
module tb_vault_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail = 0;

    vault_if #(.NUM_PHASES(5)) bus ();

    vault_sequencer #(
        .NUM_PHASES    (5),
        .MAX_RETRIES   (3),
        .PHASE_TIMEOUT (16),
        .RST_CYCLES    (2),
        .LOCKOUT_CYCLES(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic do_abort();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
    endtask

    // Expect phase_en[j] low after lat-1 edges and high at edge lat.
    task automatic expect_rise(input int j, input int lat);
        repeat (lat - 1) step();
        check($sformatf("en%0d_pre", j), 32'(bus.phase_en[j]), 0);
        step();
        check($sformatf("en%0d_rise", j), 32'(bus.phase_en[j]), 1);
        check($sformatf("cur%0d", j), 32'(bus.cur_phase), 32'(j));
    endtask

    task automatic done_phase(input int i);
        step();
        step();
        bus.phase_done[i] = 1'b1;
        step();
        bus.phase_done[i] = 1'b0;
    endtask

    task automatic run_to(input int last);
        do_start();
        expect_rise(0, 3);
        for (int i = 0; i < last; i++) begin
            done_phase(i);
            expect_rise(i + 1, 4);
        end
    endtask

    task automatic inject_fail(input int i);
        step();
        bus.phase_fail[i] = 1'b1;
        step();
        bus.phase_fail[i] = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acnt;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.phase_done = '0;
        bus.phase_fail = '0;
        step();
        check("rst_phase_rst", 32'(bus.phase_rst), 32'h1f);
        check("rst_phase_en", 32'(bus.phase_en), 0);
        check("rst_cur", 32'(bus.cur_phase), 0);
        check("rst_fail_cnt", 32'(bus.fail_cnt), 0);
        check("rst_flags", {29'd0, bus.busy, bus.vault_open, bus.alarm}, 0);
        reset = 1'b0;
        step();

        // Happy path
        run_to(4);
        check("hp_busy", 32'(bus.busy), 1);
        done_phase(4);
        step();
        check("hp_open_pre", 32'(bus.vault_open), 0);
        step();
        check("hp_open", 32'(bus.vault_open), 1);
        check("hp_fail_cnt", 32'(bus.fail_cnt), 0);
        check("hp_alarm", 32'(bus.alarm), 0);
        check("hp_rst_all", 32'(bus.phase_rst), 32'h1f);
        check("hp_busy_off", 32'(bus.busy), 0);
        do_start();
        step();
        check("open_ign_start", 32'(bus.vault_open), 1);
        do_abort();
        check("open_abort", 32'(bus.vault_open), 0);

        // Single retry in phase 1
        run_to(1);
        step();
        bus.phase_fail[1] = 1'b1;
        step();
        bus.phase_fail[1] = 1'b0;
        step();
        check("retry_fail_cnt", 32'(bus.fail_cnt), 1);
        check("retry_en_off", 32'(bus.phase_en[1]), 0);
        check("retry_rst_on", 32'(bus.phase_rst[1]), 1);
        expect_rise(1, 3);
        for (int i = 1; i < 4; i++) begin
            done_phase(i);
            expect_rise(i + 1, 4);
        end
        done_phase(4);
        step();
        step();
        check("retry_open", 32'(bus.vault_open), 1);
        check("retry_fail_keep", 32'(bus.fail_cnt), 1);
        do_abort();
        check("abort_fail_clr", 32'(bus.fail_cnt), 0);

        // Timeout in phase 2
        run_to(2);
        repeat (15) step();
        check("to_en_hold", 32'(bus.phase_en[2]), 1);
        check("to_cnt_pre", 32'(bus.fail_cnt), 0);
        step();
        check("to_en_drop", 32'(bus.phase_en[2]), 0);
        check("to_cnt", 32'(bus.fail_cnt), 1);
        expect_rise(2, 3);

        // Two more fails -> lockout
        inject_fail(2);
        check("lk_cnt2", 32'(bus.fail_cnt), 2);
        expect_rise(2, 3);
        step();
        bus.phase_fail[2] = 1'b1;
        step();
        bus.phase_fail[2] = 1'b0;
        step();
        check("lk_cnt3", 32'(bus.fail_cnt), 3);
        check("lk_alarm_pre", 32'(bus.alarm), 0);
        acnt = 0;
        for (int k = 0; k < 20; k++) begin
            bus.start = (k == 2);
            step();
            if (bus.alarm) acnt++;
        end
        bus.start = 1'b0;
        check("lk_alarm_len", 32'(acnt), 8);
        check("lk_idle_busy", 32'(bus.busy), 0);
        check("lk_fail_clr", 32'(bus.fail_cnt), 0);
        check("lk_en", 32'(bus.phase_en), 0);

        // Spurious done and done+fail collision on phase 0
        run_to(0);
        step();
        bus.phase_done[3] = 1'b1;
        step();
        bus.phase_done[3] = 1'b0;
        step();
        check("spur_cur", 32'(bus.cur_phase), 0);
        check("spur_en", 32'(bus.phase_en), 32'h01);
        bus.phase_done[0] = 1'b1;
        bus.phase_fail[0] = 1'b1;
        step();
        bus.phase_done[0] = 1'b0;
        bus.phase_fail[0] = 1'b0;
        step();
        check("coll_fail_cnt", 32'(bus.fail_cnt), 1);
        check("coll_cur", 32'(bus.cur_phase), 0);
        expect_rise(0, 3);
        do_abort();

        // Abort in phase 3 RUN
        run_to(3);
        step();
        do_abort();
        check("ab_rst", 32'(bus.phase_rst), 32'h1f);
        check("ab_en", 32'(bus.phase_en), 0);
        check("ab_cur", 32'(bus.cur_phase), 0);
        check("ab_busy", 32'(bus.busy), 0);

        // Async reset between edges
        run_to(1);
        #3;
        reset = 1'b1;
        #1;
        check("ar_en", 32'(bus.phase_en), 0);
        check("ar_rst", 32'(bus.phase_rst), 32'h1f);
        check("ar_cur", 32'(bus.cur_phase), 0);
        check("ar_busy", 32'(bus.busy), 0);
        #1;
        reset = 1'b0;
        step();
        step();
        check("ar_stay_idle", 32'(bus.phase_en), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
